// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - bus bundle for the parametrised register file
// Signals:
//   D, WA, WE      write data / address / enable
//   RAA, RAE       port A read address / enable
//   RBA, RBE       port B read address / enable
//   clr            request clear of the whole array
//   portA, portB   registered read data
//   busy           clear engine active
// Modports: master drives requests and sees read data; slave is the register file.
interface regfile_param_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic [WIDTH-1:0] D;
  logic [AW-1:0]    WA;
  logic             WE;
  logic [AW-1:0]    RAA;
  logic [AW-1:0]    RBA;
  logic             RAE;
  logic             RBE;
  logic             clr;
  logic [WIDTH-1:0] portA;
  logic [WIDTH-1:0] portB;
  logic             busy;

  modport master (
    output D, WA, WE, RAA, RBA, RAE, RBE, clr,
    input  portA, portB, busy
  );

  modport slave (
    input  D, WA, WE, RAA, RBA, RAE, RBE, clr,
    output portA, portB, busy
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - two-read/one-write register file with bypass and clear engine
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   regfile_param_if.slave: D/WA/WE write, RAA/RAE and RBA/RBE reads,
//         clr request, portA/portB registered read data, busy
// Parameters: WIDTH data width, DEPTH entries (power of two), AW derived,
//             ZERO_REG=1 hard-wires entry 0 to zero.
module regfile_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] porta_q, portb_q;
  logic [WIDTH-1:0] rda_nx, rdb_nx;
  logic             wr_en;
  logic             zero_en;

  // Clear sequencer: one entry per cycle, counter wraps to 0 on the last one.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        cnt_nx = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A write is dropped while clearing and on the clr request cycle itself.
  always_comb begin
    wr_en   = bus.WE && (state == IDLE) && !bus.clr &&
              !((ZERO_REG != 0) && (bus.WA == '0));
    zero_en = (state == CLEAR);
  end

  // Read data reflects the array as it will be after this edge.
  always_comb begin
    rda_nx = '0;
    if (bus.RAE) begin
      if ((ZERO_REG != 0) && (bus.RAA == '0)) rda_nx = '0;
      else if (wr_en && (bus.WA == bus.RAA))  rda_nx = bus.D;
      else if (zero_en && (cnt == bus.RAA))   rda_nx = '0;
      else                                    rda_nx = mem[bus.RAA];
    end
  end

  always_comb begin
    rdb_nx = '0;
    if (bus.RBE) begin
      if ((ZERO_REG != 0) && (bus.RBA == '0)) rdb_nx = '0;
      else if (wr_en && (bus.WA == bus.RBA))  rdb_nx = bus.D;
      else if (zero_en && (cnt == bus.RBA))   rdb_nx = '0;
      else                                    rdb_nx = mem[bus.RBA];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      porta_q <= '0;
      portb_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      porta_q <= rda_nx;
      portb_q <= rdb_nx;
      if (wr_en)   mem[bus.WA] <= bus.D;
      if (zero_en) mem[cnt]    <= '0;
    end
  end

  assign bus.portA = porta_q;
  assign bus.portB = portb_q;
  assign bus.busy  = (state == CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (three configurations)
module tb_regfile_param;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-instance stimulus: 0 = 8x4, 1 = 8x4 with zero register, 2 = 16x16
  logic        t_rst [3];
  logic [15:0] t_d   [3];
  logic [3:0]  t_wa  [3];
  logic        t_we  [3];
  logic [3:0]  t_raa [3];
  logic [3:0]  t_rba [3];
  logic        t_rae [3];
  logic        t_rbe [3];
  logic        t_clr [3];

  regfile_param_if #(.WIDTH(8),  .AW(2)) if0 ();
  regfile_param_if #(.WIDTH(8),  .AW(2)) if1 ();
  regfile_param_if #(.WIDTH(16), .AW(4)) if2 ();

  assign if0.D = t_d[0][7:0];  assign if0.WA = t_wa[0][1:0]; assign if0.WE = t_we[0];
  assign if0.RAA = t_raa[0][1:0]; assign if0.RBA = t_rba[0][1:0];
  assign if0.RAE = t_rae[0]; assign if0.RBE = t_rbe[0]; assign if0.clr = t_clr[0];
  assign if1.D = t_d[1][7:0];  assign if1.WA = t_wa[1][1:0]; assign if1.WE = t_we[1];
  assign if1.RAA = t_raa[1][1:0]; assign if1.RBA = t_rba[1][1:0];
  assign if1.RAE = t_rae[1]; assign if1.RBE = t_rbe[1]; assign if1.clr = t_clr[1];
  assign if2.D = t_d[2];       assign if2.WA = t_wa[2];      assign if2.WE = t_we[2];
  assign if2.RAA = t_raa[2];   assign if2.RBA = t_rba[2];
  assign if2.RAE = t_rae[2]; assign if2.RBE = t_rbe[2]; assign if2.clr = t_clr[2];

  regfile_param #(.WIDTH(8),  .DEPTH(4),  .ZERO_REG(0)) u0 (.clk(clk), .rst(t_rst[0]), .bus(if0));
  regfile_param #(.WIDTH(8),  .DEPTH(4),  .ZERO_REG(1)) u1 (.clk(clk), .rst(t_rst[1]), .bus(if1));
  regfile_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0)) u2 (.clk(clk), .rst(t_rst[2]), .bus(if2));

  // Behavioural model: array contents after each edge; a clear started at edge N
  // zeroes entry k at edge N+1+k and is busy for edges N..N+DEPTH-1.
  int          dp    [3] = '{4, 4, 16};
  bit          zr    [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] wmask [3] = '{16'h00ff, 16'h00ff, 16'hffff};
  logic [15:0] m_mem [3][16];
  logic [15:0] m_a   [3];
  logic [15:0] m_b   [3];
  logic        m_busy[3];
  int          m_clr_e[3];
  bit          m_valid[3] = '{1'b0, 1'b0, 1'b0};

  int vectors     = 0;
  int miscompares = 0;
  int nedge       = 0;
  int sedge       = 0;

  typedef struct {
    int          e;
    int          inst;
    int          sel;
    logic [15:0] val;
    string       nm;
  } lit_t;
  lit_t lit_q[$];
  int   lit_rd = 0;

  function automatic void step(int i, int e);
    int z;
    if (t_rst[i]) begin
      for (int k = 0; k < 16; k++) m_mem[i][k] = '0;
      m_a[i] = '0; m_b[i] = '0; m_busy[i] = 1'b0; m_valid[i] = 1'b1;
      return;
    end
    if (m_busy[i]) begin
      z = e - m_clr_e[i] - 1;
      m_mem[i][z] = '0;
      m_busy[i] = (e - m_clr_e[i]) < dp[i];
    end else if (t_clr[i]) begin
      m_clr_e[i] = e;
      m_busy[i]  = 1'b1;
    end else if (t_we[i] && !(zr[i] && t_wa[i] == 0)) begin
      m_mem[i][t_wa[i]] = t_d[i] & wmask[i];
    end
    m_a[i] = (t_rae[i] && !(zr[i] && t_raa[i] == 0)) ? m_mem[i][t_raa[i]] : 16'h0;
    m_b[i] = (t_rbe[i] && !(zr[i] && t_rba[i] == 0)) ? m_mem[i][t_rba[i]] : 16'h0;
  endfunction

  function automatic logic [15:0] dut_val(int i, int sel);
    logic [15:0] v;
    v = '0;
    case (i)
      0: v = (sel == 0) ? 16'(if0.portA) : (sel == 1) ? 16'(if0.portB) : 16'(if0.busy);
      1: v = (sel == 0) ? 16'(if1.portA) : (sel == 1) ? 16'(if1.portB) : 16'(if1.busy);
      default: v = (sel == 0) ? if2.portA : (sel == 1) ? if2.portB : 16'(if2.busy);
    endcase
    return v;
  endfunction

  function automatic logic [15:0] model_val(int i, int sel);
    return (sel == 0) ? m_a[i] : (sel == 1) ? m_b[i] : 16'(m_busy[i]);
  endfunction

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s edge %0d: actual %h required %h", nm, nedge, act, exp);
    end
  endfunction

  // Compare process: outputs after edge k are checked at the following negedge,
  // then the model advances using the inputs set up for edge k+1.
  initial begin
    string pn [3] = '{"portA", "portB", "busy"};
    #2;
    for (int i = 0; i < 3; i++) step(i, 1);
    forever begin
      @(negedge clk);
      nedge++;
      for (int i = 0; i < 3; i++)
        if (m_valid[i])
          for (int s = 0; s < 3; s++)
            chk($sformatf("model u%0d %s", i, pn[s]), dut_val(i, s), model_val(i, s));
      while (lit_rd < lit_q.size() && lit_q[lit_rd].e <= nedge) begin
        chk({lit_q[lit_rd].nm, " dut"},   dut_val(lit_q[lit_rd].inst, lit_q[lit_rd].sel),   lit_q[lit_rd].val);
        chk({lit_q[lit_rd].nm, " model"}, model_val(lit_q[lit_rd].inst, lit_q[lit_rd].sel), lit_q[lit_rd].val);
        lit_rd++;
      end
      for (int i = 0; i < 3; i++) step(i, nedge + 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    sedge++;
    #1;
  endtask

  task automatic wr(int i, logic we, int wa, logic [15:0] d, logic clr);
    t_we[i] = we; t_wa[i] = 4'(wa); t_d[i] = d; t_clr[i] = clr;
  endtask

  task automatic rd(int i, logic rae, int raa, logic rbe, int rba);
    t_rae[i] = rae; t_raa[i] = 4'(raa); t_rbe[i] = rbe; t_rba[i] = 4'(rba);
  endtask

  // Hand-computed value expected on output sel of instance i after the next edge
  task automatic lit(int i, int sel, logic [15:0] v, string nm);
    lit_t l;
    l.e = sedge + 1; l.inst = i; l.sel = sel; l.val = v; l.nm = nm;
    lit_q.push_back(l);
  endtask

  localparam int A = 0, B = 1, BSY = 2;

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_rst[i] = 1'b1;
      wr(i, 1'b0, 0, 16'h0, 1'b0);
      rd(i, 1'b1, 0, 1'b1, 0);
    end
    lit(0, A, 16'h0, "reset portA");
    lit(0, BSY, 16'h0, "reset busy");
    lit(2, B, 16'h0, "reset portB u2");
    tick();
    for (int i = 0; i < 3; i++) t_rst[i] = 1'b0;

    // Basic writes and bypass
    wr(0, 1'b1, 3, 16'd23, 1'b0); tick();
    wr(0, 1'b1, 1, 16'd45, 1'b0); rd(0, 1'b1, 3, 1'b1, 1);
    lit(0, A, 16'd23, "read 3"); lit(0, B, 16'd45, "bypass 1"); tick();
    wr(0, 1'b1, 2, 16'd67, 1'b0); tick();
    wr(0, 1'b1, 0, 16'd89, 1'b0); tick();
    wr(0, 1'b0, 0, 16'h0, 1'b0); rd(0, 1'b1, 0, 1'b1, 2);
    lit(0, A, 16'd89, "read 0"); lit(0, B, 16'd67, "read 2"); tick();

    // Hard-wired zero register
    wr(1, 1'b1, 0, 16'h00aa, 1'b0); rd(1, 1'b1, 0, 1'b1, 0);
    lit(1, A, 16'h0, "zreg write-0 no bypass"); tick();
    wr(1, 1'b1, 1, 16'h0055, 1'b0); rd(1, 1'b1, 0, 1'b1, 1);
    lit(1, A, 16'h0, "zreg read 0"); lit(1, B, 16'h0055, "zreg bypass 1"); tick();
    wr(1, 1'b0, 0, 16'h0, 1'b0); rd(1, 1'b0, 1, 1'b1, 1);
    lit(1, A, 16'h0, "zreg RAE=0"); lit(1, B, 16'h0055, "zreg read 1"); tick();
    rd(1, 1'b1, 1, 1'b0, 1);
    lit(1, A, 16'h0055, "zreg portA 1"); lit(1, B, 16'h0, "zreg RBE=0"); tick();

    // Fill, then clear with a colliding write
    for (int k = 0; k < 4; k++) begin
      wr(0, 1'b1, k, 16'(k + 1), 1'b0); tick();
    end
    wr(0, 1'b1, 2, 16'd99, 1'b1); rd(0, 1'b1, 2, 1'b1, 3);
    lit(0, A, 16'd3, "clr drops write"); lit(0, B, 16'd4, "pre-clear 3");
    lit(0, BSY, 16'h1, "busy after clr"); tick();
    for (int j = 1; j <= 4; j++) begin
      wr(0, 1'b1, 1, 16'd7, (j == 2));
      rd(0, 1'b1, 3, 1'b1, 1);
      lit(0, BSY, (j < 4) ? 16'h1 : 16'h0, $sformatf("busy clr+%0d", j));
      lit(0, A, (j < 4) ? 16'd4 : 16'd0, $sformatf("hold 3 clr+%0d", j));
      lit(0, B, (j < 2) ? 16'd2 : 16'd0, $sformatf("read 1 clr+%0d", j));
      tick();
    end
    wr(0, 1'b1, 1, 16'd5, 1'b0); rd(0, 1'b1, 1, 1'b1, 2);
    lit(0, A, 16'd5, "first write after clr"); lit(0, B, 16'd0, "cleared 2");
    lit(0, BSY, 16'h0, "idle after clr"); tick();
    wr(0, 1'b0, 0, 16'h0, 1'b0); rd(0, 1'b1, 0, 1'b1, 3);
    lit(0, A, 16'd0, "cleared 0"); lit(0, B, 16'd0, "cleared 3"); tick();

    // Reset in the middle of a clear
    wr(0, 1'b1, 0, 16'h11, 1'b0); tick();
    wr(0, 1'b1, 3, 16'h33, 1'b0); tick();
    wr(0, 1'b0, 0, 16'h0, 1'b1); rd(0, 1'b1, 3, 1'b1, 0);
    lit(0, BSY, 16'h1, "busy M"); lit(0, A, 16'h33, "read 3 M"); lit(0, B, 16'h11, "read 0 M"); tick();
    wr(0, 1'b0, 0, 16'h0, 1'b0); tick();
    t_rst[0] = 1'b1;
    lit(0, BSY, 16'h0, "rst mid-clear busy"); lit(0, A, 16'h0, "rst portA"); tick();
    t_rst[0] = 1'b0; rd(0, 1'b1, 3, 1'b1, 1);
    lit(0, A, 16'h0, "after rst 3"); lit(0, B, 16'h0, "after rst 1"); tick();
    wr(0, 1'b1, 3, 16'd9, 1'b0); rd(0, 1'b1, 3, 1'b1, 3);
    lit(0, A, 16'd9, "write after rst"); tick();
    wr(0, 1'b0, 0, 16'h0, 1'b0); tick();

    // Wide/deep configuration
    wr(2, 1'b1, 15, 16'hbeef, 1'b0); tick();
    wr(2, 1'b1, 0, 16'h1234, 1'b0); tick();
    wr(2, 1'b0, 0, 16'h0, 1'b0); rd(2, 1'b1, 15, 1'b1, 0);
    lit(2, A, 16'hbeef, "u2 read 15"); lit(2, B, 16'h1234, "u2 read 0"); tick();
    wr(2, 1'b0, 0, 16'h0, 1'b1);
    lit(2, BSY, 16'h1, "u2 busy K"); lit(2, B, 16'h1234, "u2 read 0 K"); tick();
    for (int j = 0; j < 16; j++) begin
      wr(2, 1'b0, 0, 16'h0, 1'b0);
      lit(2, BSY, (j < 15) ? 16'h1 : 16'h0, $sformatf("u2 busy K+%0d", j + 1));
      lit(2, A, (j < 15) ? 16'hbeef : 16'h0, $sformatf("u2 hold 15 K+%0d", j + 1));
      lit(2, B, 16'h0, $sformatf("u2 read 0 K+%0d", j + 1));
      tick();
    end
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
